nina_cpu_bus_master: RTL
========================

# nina_cpu_bus_master

CPU-side bus-cycle generator for NINA-style discrete mappers (cartridge tester / dumper front end). It turns a valid/ready command stream of single reads and writes into NES CPU bus cycles: a free-running M2, /ROMSEL decoded from A15, R/W, address and data. Bank-register writes are plain write commands, e.g. address 0x4100 with A14:13=10 and A8=1. Between commands it runs idle dummy reads so M2 never stops. Responses return read data and acknowledge writes.

## Interface
- M2_LOW_CLKS, 6, clk periods per M2-low phase; legal range 2..255
- M2_HIGH_CLKS, 6, clk periods per M2-high phase; legal range 2..255
- clk  in  1  sole clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted on this clk when cmd_valid is also high
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  16  full CPU address; bit 15 drives /ROMSEL decode
- cmd_wdata  in  8  write data
- rsp_valid  out  1  one-clk pulse at command completion (reads and writes)
- rsp_rdata  out  8  read data; updated only by read commands
- m2  out  1  CPU M2 clock
- romsel  out  1  /ROMSEL, active-low
- cpu_rw_out  out  1  1 = read, 0 = write
- cpu_addr_out  out  15  A14:A0
- cpu_data_out  out  8  data driven on writes
- cpu_data_oe  out  1  data bus output enable
- cpu_data_in  in  8  data bus sampled on reads

## Operation
- Each bus cycle is a LOW phase (M2_LOW_CLKS clks, m2=0) followed by a HIGH phase (M2_HIGH_CLKS clks, m2=1). One phase counter is sized to the larger parameter.
- States:
  - LOW→HIGH when the counter reaches M2_LOW_CLKS-1.
  - HIGH→LOW when the counter reaches M2_HIGH_CLKS-1.
  - The counter clears at each transition.
- cmd_ready=1 only on the last clk of a HIGH phase. The handshake there loads the command into the cycle that starts next clk.
- With no handshake, the next cycle is a dummy read: addr 0x0000, rw=1, romsel=1, no response.
- At LOW-phase entry, cpu_addr_out, cpu_rw_out, cpu_data_out and the A15 flag are registered and held for the whole cycle.
- romsel = ~(A15 & m2): low exactly during the HIGH phase when A15=1, high otherwise.
- cpu_data_oe=1 only during the HIGH phase of a write cycle; 0 on reads and dummies.
- Reads: cpu_data_in is sampled on the last HIGH clk.
- Completion: rsp_valid pulses on the first clk of the following LOW phase.
  - Read: rsp_rdata carries the sampled byte.
  - Write: rsp_rdata keeps its previous value.
- A command accepted on the same clk that completes the previous one is legal. Back-to-back commands yield consecutive cycles with no dummy between.
- cmd_* inputs are ignored when cmd_ready=0; a command offered and then withdrawn before cmd_ready is never executed.

## Timing
- Reset values: m2=0, romsel=1, cpu_rw_out=1, cpu_addr_out=0, cpu_data_out=0, cpu_data_oe=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, phase=LOW, counter=0.
- After reset deasserts, a dummy cycle begins immediately. The first cmd_ready is at clk M2_LOW_CLKS+M2_HIGH_CLKS-1 counted from the first non-reset clk.
- M2 period = M2_LOW_CLKS+M2_HIGH_CLKS clks, duty exact, no glitches; all outputs registered.
- Latency: handshake at clk t → rsp_valid at t+M2_LOW_CLKS+M2_HIGH_CLKS+1.
- Throughput: one command per M2 period maximum.
- Reset mid-cycle: all outputs return to reset values on the next edge. The in-flight command is dropped with no rsp_valid.
  - Reset during a write HIGH phase produces a truncated M2 pulse. This is documented behaviour; software must not reset during bank writes.

## Test plan
- Idle after reset (LOW=HIGH=3): m2 toggles 3/3 clks, cmd_ready pulses every 6 clks on the last HIGH clk, rw=1, romsel=1, data_oe=0, rsp_valid never set.
- Bank write 0x4100←0x0A, mapper model attached:
  - Bus: addr=0x4100, rw=0 for the full cycle, romsel stays 1, data_oe=1 with data 0x0A for exactly the 3 HIGH clks.
  - Mapper: model bank=0xA after M2 falls.
  - Response: rsp_valid 7 clks after the handshake.
- ROM read 0x8123 with cpu_data_in=0x5A on the last HIGH clk: romsel=0 for exactly 3 clks aligned to m2=1, addr=0x0123, rsp_rdata=0x5A with rsp_valid at handshake+7.
- Back-to-back: cmd_valid held high for write 0x4100←0x03 then read 0xC000. Two consecutive cycles with no dummy between, two rsp_valid pulses 6 clks apart, rsp_rdata unchanged after the write.
- Withdrawn command: cmd_valid high for 2 clks not overlapping cmd_ready → no accepted cycle, addr stays 0x0000, no rsp_valid.
- Reset on the 2nd HIGH clk of a write: next clk m2=0, rw=1, data_oe=0, romsel=1; no rsp_valid; a fresh dummy cycle follows reset release.

Source files
------------

// File: rtl/nina_cpu_bus_master.sv
// CPU-side bus-cycle generator for NINA-style mappers: free-running M2 with
// command-driven read/write cycles and idle dummy reads between commands.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_LOW  | M2 low; address, R/W and write data set up for the cycle
// ST_HIGH | M2 high; /ROMSEL and data drive active, read data sampled
module nina_cpu_bus_master #(
   parameter int M2_LOW_CLKS  = 6,
   parameter int M2_HIGH_CLKS = 6
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [15:0] cmd_addr,
   input  logic [7:0]  cmd_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        m2,
   output logic        romsel,
   output logic        cpu_rw_out,
   output logic [14:0] cpu_addr_out,
   output logic [7:0]  cpu_data_out,
   output logic        cpu_data_oe,
   input  logic [7:0]  cpu_data_in
);

   localparam int MAX_CLKS = (M2_LOW_CLKS > M2_HIGH_CLKS) ? M2_LOW_CLKS : M2_HIGH_CLKS;
   localparam int CW = $clog2(MAX_CLKS);
   localparam logic [CW-1:0] LOW_LAST  = CW'(M2_LOW_CLKS - 1);
   localparam logic [CW-1:0] HIGH_LAST = CW'(M2_HIGH_CLKS - 1);

   typedef enum logic {ST_LOW, ST_HIGH} state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_cmd;
   logic          r_a15;

   logic          w_low_done;
   logic          w_high_done;
   logic          w_accept;
   logic          w_cmd_nxt;
   logic          w_a15_nxt;
   logic          w_rw_nxt;
   logic [14:0]   w_addr_nxt;
   logic [7:0]    w_wdata_nxt;
   logic          w_m2_nxt;
   logic          w_ready_nxt;
   logic          w_romsel_nxt;
   logic          w_oe_nxt;
   logic          w_rsp_nxt;
   logic [7:0]    w_rdata_nxt;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_low_done  = (r_state == ST_LOW)  && (r_cnt == LOW_LAST);
      w_high_done = (r_state == ST_HIGH) && (r_cnt == HIGH_LAST);
      w_accept    = cmd_ready & cmd_valid;
      w_cmd_nxt   = r_cmd;
      w_a15_nxt   = r_a15;
      w_rw_nxt    = cpu_rw_out;
      w_addr_nxt  = cpu_addr_out;
      w_wdata_nxt = cpu_data_out;

      if (w_low_done) begin
         w_state_nxt = ST_HIGH;
         w_cnt_nxt   = '0;
      end else if (w_high_done) begin
         w_state_nxt = ST_LOW;
         w_cnt_nxt   = '0;
         w_cmd_nxt   = w_accept;
         // Without a handshake the next cycle is a harmless dummy read of 0x0000
         if (w_accept) begin
            w_a15_nxt   = cmd_addr[15];
            w_rw_nxt    = ~cmd_write;
            w_addr_nxt  = cmd_addr[14:0];
            w_wdata_nxt = cmd_wdata;
         end else begin
            w_a15_nxt   = 1'b0;
            w_rw_nxt    = 1'b1;
            w_addr_nxt  = '0;
            w_wdata_nxt = '0;
         end
      end

      w_m2_nxt     = (w_state_nxt == ST_HIGH);
      w_ready_nxt  = w_m2_nxt && (w_cnt_nxt == HIGH_LAST);
      w_romsel_nxt = ~(w_a15_nxt & w_m2_nxt);
      w_oe_nxt     = w_m2_nxt & ~w_rw_nxt;
      w_rsp_nxt    = w_high_done & r_cmd;
      w_rdata_nxt  = (w_high_done && r_cmd && cpu_rw_out) ? cpu_data_in : rsp_rdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_LOW;
         r_cnt        <= '0;
         r_cmd        <= 1'b0;
         r_a15        <= 1'b0;
         m2           <= 1'b0;
         romsel       <= 1'b1;
         cpu_rw_out   <= 1'b1;
         cpu_addr_out <= '0;
         cpu_data_out <= '0;
         cpu_data_oe  <= 1'b0;
         cmd_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_cmd        <= w_cmd_nxt;
         r_a15        <= w_a15_nxt;
         m2           <= w_m2_nxt;
         romsel       <= w_romsel_nxt;
         cpu_rw_out   <= w_rw_nxt;
         cpu_addr_out <= w_addr_nxt;
         cpu_data_out <= w_wdata_nxt;
         cpu_data_oe  <= w_oe_nxt;
         cmd_ready    <= w_ready_nxt;
         rsp_valid    <= w_rsp_nxt;
         rsp_rdata    <= w_rdata_nxt;
      end
   end

endmodule
